// File: rtl/gp_count_adv_n.sv
// gp_count_adv_n: parametrised up/down counter cell with prescaler,
// reload-on-terminal-count and optional one-shot halt.
//
// Ports:
//   CLK   in   counter clock, rising edge
//   RST   in   async active-high reset, level-sensitive
//   UP    in   1: count up, 0: count down (taken at the tick edge)
//   KEEP  in   1: freeze counter and prescaler
//   OUT   out  terminal-count flag (combinational)
//   POUT  out  low POUT_WIDTH bits of the count
module gp_count_adv_n #(
  parameter int    WIDTH        = 14,
  parameter int    COUNT_TO     = 1,
  parameter int    CLKIN_DIVIDE = 1,
  parameter string RESET_VALUE  = "ZERO",
  parameter int    ONESHOT      = 0,
  parameter int    POUT_WIDTH   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  UP,
  input  logic                  KEEP,
  output logic                  OUT,
  output logic [POUT_WIDTH-1:0] POUT
);

  localparam bit RV_IS_ZERO = (RESET_VALUE == "ZERO");
  localparam bit RV_IS_CT   = (RESET_VALUE == "COUNT_TO");
  localparam bit OS         = (ONESHOT != 0);

  generate
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("gp_count_adv_n: WIDTH must be 2..16");
    end
    if (COUNT_TO < 0 || COUNT_TO >= (1 << WIDTH)) begin : g_bad_ct
      $error("gp_count_adv_n: COUNT_TO out of range");
    end
    if (CLKIN_DIVIDE < 1 || CLKIN_DIVIDE > 256) begin : g_bad_div
      $error("gp_count_adv_n: CLKIN_DIVIDE must be 1..256");
    end
    if (POUT_WIDTH < 1 || POUT_WIDTH > WIDTH) begin : g_bad_pw
      $error("gp_count_adv_n: POUT_WIDTH must be 1..WIDTH");
    end
    if (!RV_IS_ZERO && !RV_IS_CT) begin : g_bad_rv
      $error("gp_count_adv_n: RESET_VALUE must be ZERO or COUNT_TO");
    end
  endgenerate

  localparam logic [WIDTH-1:0] CT  = WIDTH'(COUNT_TO);
  localparam logic [WIDTH-1:0] TOP = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] RV  = RV_IS_CT ? CT : '0;
  localparam logic [7:0]       DM1 = 8'(CLKIN_DIVIDE - 1);

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [7:0]       pdiv_q, pdiv_d;

  logic halted;
  logic at_top;
  logic at_zero;
  logic term;
  logic tick;

  assign halted  = (state_q == ST_HALT);
  assign at_top  = (count_q == TOP);
  assign at_zero = (count_q == '0);
  // Terminal test in the current direction; also gates the
  // reload so the modulo wrap is never taken.
  assign term    = UP ? at_top : at_zero;
  assign tick    = (pdiv_q == DM1) & ~KEEP & ~halted;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_RUN;
      count_q <= RV;
      pdiv_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pdiv_q  <= pdiv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pdiv_d  = pdiv_q;
    if (!KEEP && !halted) begin
      pdiv_d = tick ? 8'd0 : pdiv_q + 8'd1;
    end
    if (tick) begin
      if (term) begin
        if (OS) begin
          state_d = ST_HALT;
        end else begin
          count_d = CT;
        end
      end else if (UP) begin
        count_d = count_q + 1'b1;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Once halted the flag is sticky regardless of UP.
  assign OUT  = halted | term;
  assign POUT = count_q[POUT_WIDTH-1:0];

endmodule

// File: tb/tb_gp_count_adv_n.sv
// tb_gp_count_adv_n: directed and randomized checks of gp_count_adv_n
// across five parameter sets against an integer reference model.
module tb_gp_count_adv_n;

  localparam int P_W  [5] = '{8, 8, 4, 8, 14};
  localparam int P_CT [5] = '{3, 2, 5, 2, 16383};
  localparam int P_DIV[5] = '{1, 4, 1, 1, 1};
  localparam int P_RV [5] = '{0, 1, 0, 0, 0};
  localparam int P_OS [5] = '{0, 0, 0, 1, 0};
  localparam int P_PW [5] = '{8, 8, 4, 8, 8};

  logic       clk;
  logic [4:0] rst;
  logic [4:0] up;
  logic [4:0] keep;
  logic [4:0] out;
  logic [7:0] pa, pb, pd, pe;
  logic [3:0] pc;

  int n_chk;
  int n_fail;

  int m_cnt [5];
  int m_pd  [5];
  bit m_halt[5];

  always #5 clk = ~clk;

  gp_count_adv_n #(.WIDTH(8), .COUNT_TO(3), .CLKIN_DIVIDE(1),
    .RESET_VALUE("ZERO"), .ONESHOT(0), .POUT_WIDTH(8)) u_a (
    .CLK(clk), .RST(rst[0]), .UP(up[0]), .KEEP(keep[0]),
    .OUT(out[0]), .POUT(pa));

  gp_count_adv_n #(.WIDTH(8), .COUNT_TO(2), .CLKIN_DIVIDE(4),
    .RESET_VALUE("COUNT_TO"), .ONESHOT(0), .POUT_WIDTH(8)) u_b (
    .CLK(clk), .RST(rst[1]), .UP(up[1]), .KEEP(keep[1]),
    .OUT(out[1]), .POUT(pb));

  gp_count_adv_n #(.WIDTH(4), .COUNT_TO(5), .CLKIN_DIVIDE(1),
    .RESET_VALUE("ZERO"), .ONESHOT(0), .POUT_WIDTH(4)) u_c (
    .CLK(clk), .RST(rst[2]), .UP(up[2]), .KEEP(keep[2]),
    .OUT(out[2]), .POUT(pc));

  gp_count_adv_n #(.WIDTH(8), .COUNT_TO(2), .CLKIN_DIVIDE(1),
    .RESET_VALUE("ZERO"), .ONESHOT(1), .POUT_WIDTH(8)) u_d (
    .CLK(clk), .RST(rst[3]), .UP(up[3]), .KEEP(keep[3]),
    .OUT(out[3]), .POUT(pd));

  gp_count_adv_n #(.WIDTH(14), .COUNT_TO(16383), .CLKIN_DIVIDE(1),
    .RESET_VALUE("ZERO"), .ONESHOT(0), .POUT_WIDTH(8)) u_e (
    .CLK(clk), .RST(rst[4]), .UP(up[4]), .KEEP(keep[4]),
    .OUT(out[4]), .POUT(pe));

  function automatic logic [15:0] get_pout(input int i);
    case (i)
      0:       return {8'b0, pa};
      1:       return {8'b0, pb};
      2:       return {12'b0, pc};
      3:       return {8'b0, pd};
      default: return {8'b0, pe};
    endcase
  endfunction

  task automatic model_reset(input int i);
    m_cnt[i]  = (P_RV[i] != 0) ? P_CT[i] : 0;
    m_pd[i]   = 0;
    m_halt[i] = 1'b0;
  endtask

  // One rising edge: prescaler counts enabled edges, a move beyond
  // 0..2^W-1 becomes a reload or a halt.
  task automatic model_step(input int i);
    int lim;
    int nxt;
    lim = 1 << P_W[i];
    if (rst[i]) begin
      model_reset(i);
      return;
    end
    if (keep[i] || m_halt[i]) return;
    if (m_pd[i] != P_DIV[i] - 1) begin
      m_pd[i]++;
      return;
    end
    m_pd[i] = 0;
    nxt = up[i] ? m_cnt[i] + 1 : m_cnt[i] - 1;
    if (nxt < 0 || nxt >= lim) begin
      if (P_OS[i] != 0) m_halt[i] = 1'b1;
      else m_cnt[i] = P_CT[i];
    end else begin
      m_cnt[i] = nxt;
    end
  endtask

  function automatic logic exp_out(input int i);
    int lim;
    lim = 1 << P_W[i];
    return m_halt[i] ||
      (up[i] ? (m_cnt[i] == lim - 1) : (m_cnt[i] == 0));
  endfunction

  function automatic logic [15:0] exp_pout(input int i);
    return 16'(m_cnt[i] % (1 << P_PW[i]));
  endfunction

  task automatic cyc(input int i);
    @(posedge clk);
    model_step(i);
    #1;
  endtask

  task automatic pulse_reset(input int i);
    rst[i] = 1'b1;
    #1;
    model_reset(i);
    cyc(i);
    rst[i] = 1'b0;
  endtask

  task automatic test_reset;
    up[0] = 1'b0;
    keep[0] = 1'b0;
    pulse_reset(0);
    n_chk++;
    if (get_pout(0) !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d exp 0", get_pout(0));
    end
    n_chk++;
    if (out[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_out: got %b exp 1", out[0]);
    end
  endtask

  task automatic test_reload_down;
    int seq[5] = '{3, 2, 1, 0, 3};
    for (int k = 0; k < 5; k++) begin
      cyc(0);
      n_chk++;
      if (get_pout(0) !== 16'(seq[k])) begin
        n_fail++;
        $display("FAIL reload_cnt[%0d]: got %0d exp %0d",
          k, get_pout(0), seq[k]);
      end
      n_chk++;
      if (out[0] !== (seq[k] == 0)) begin
        n_fail++;
        $display("FAIL reload_out[%0d]: got %b exp %b",
          k, out[0], seq[k] == 0);
      end
    end
    rst[0] = 1'b1;
  endtask

  task automatic test_prescale_keep;
    int e;
    up[1] = 1'b0;
    keep[1] = 1'b0;
    pulse_reset(1);
    n_chk++;
    if (get_pout(1) !== 16'd2) begin
      n_fail++;
      $display("FAIL pre_reset: got %0d exp 2", get_pout(1));
    end
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      e = (k < 4) ? 2 : (k < 8) ? 1 : 0;
      n_chk++;
      if (get_pout(1) !== 16'(e)) begin
        n_fail++;
        $display("FAIL pre_cnt[%0d]: got %0d exp %0d",
          k, get_pout(1), e);
      end
    end
    keep[1] = 1'b1;
    for (int k = 0; k < 3; k++) cyc(1);
    keep[1] = 1'b0;
    n_chk++;
    if (get_pout(1) !== 16'd0 || out[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL keep_hold: got %0d/%b exp 0/1",
        get_pout(1), out[1]);
    end
    cyc(1);
    n_chk++;
    if (get_pout(1) !== 16'd0) begin
      n_fail++;
      $display("FAIL keep_pdiv: got %0d exp 0", get_pout(1));
    end
    cyc(1);
    n_chk++;
    if (get_pout(1) !== 16'd2) begin
      n_fail++;
      $display("FAIL keep_reload: got %0d exp 2", get_pout(1));
    end
    rst[1] = 1'b1;
  endtask

  task automatic test_up_wrap;
    up[2] = 1'b1;
    keep[2] = 1'b0;
    pulse_reset(2);
    for (int k = 0; k < 14; k++) cyc(2);
    n_chk++;
    if (get_pout(2) !== 16'd14 || out[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL up_14: got %0d/%b exp 14/0",
        get_pout(2), out[2]);
    end
    cyc(2);
    n_chk++;
    if (get_pout(2) !== 16'd15 || out[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL up_15: got %0d/%b exp 15/1",
        get_pout(2), out[2]);
    end
    up[2] = 1'b0;
    #1;
    n_chk++;
    if (out[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL up_drop: got %b exp 0", out[2]);
    end
    up[2] = 1'b1;
    #1;
    cyc(2);
    n_chk++;
    if (get_pout(2) !== 16'd5 || out[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL up_reload: got %0d/%b exp 5/0",
        get_pout(2), out[2]);
    end
    rst[2] = 1'b1;
  endtask

  task automatic test_oneshot;
    up[3] = 1'b1;
    keep[3] = 1'b0;
    pulse_reset(3);
    cyc(3);
    cyc(3);
    up[3] = 1'b0;
    cyc(3);
    cyc(3);
    n_chk++;
    if (get_pout(3) !== 16'd0 || out[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL os_zero: got %0d/%b exp 0/1",
        get_pout(3), out[3]);
    end
    for (int k = 0; k < 10; k++) begin
      cyc(3);
      n_chk++;
      if (get_pout(3) !== 16'd0 || out[3] !== 1'b1) begin
        n_fail++;
        $display("FAIL os_hold[%0d]: got %0d/%b exp 0/1",
          k, get_pout(3), out[3]);
      end
    end
    up[3] = 1'b1;
    cyc(3);
    n_chk++;
    if (get_pout(3) !== 16'd0 || out[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL os_up: got %0d/%b exp 0/1",
        get_pout(3), out[3]);
    end
    rst[3] = 1'b1;
    #1;
    n_chk++;
    if (get_pout(3) !== 16'd0 || out[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL os_rst: got %0d/%b exp 0/0",
        get_pout(3), out[3]);
    end
    cyc(3);
    rst[3] = 1'b0;
    cyc(3);
    n_chk++;
    if (get_pout(3) !== 16'd1) begin
      n_fail++;
      $display("FAIL os_resume: got %0d exp 1", get_pout(3));
    end
    rst[3] = 1'b1;
  endtask

  task automatic test_async_reset;
    int e;
    up[1] = 1'b0;
    keep[1] = 1'b0;
    pulse_reset(1);
    for (int k = 0; k < 6; k++) cyc(1);
    n_chk++;
    if (get_pout(1) !== 16'd1) begin
      n_fail++;
      $display("FAIL ar_pre: got %0d exp 1", get_pout(1));
    end
    #2;
    rst[1] = 1'b1;
    #1;
    n_chk++;
    if (get_pout(1) !== 16'd2) begin
      n_fail++;
      $display("FAIL ar_clear: got %0d exp 2", get_pout(1));
    end
    #1;
    rst[1] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      e = (k < 4) ? 2 : 1;
      n_chk++;
      if (get_pout(1) !== 16'(e)) begin
        n_fail++;
        $display("FAIL ar_tick[%0d]: got %0d exp %0d",
          k, get_pout(1), e);
      end
    end
    rst[1] = 1'b1;
  endtask

  task automatic test_wide;
    up[4] = 1'b0;
    keep[4] = 1'b0;
    pulse_reset(4);
    cyc(4);
    n_chk++;
    if (get_pout(4) !== 16'hFF || out[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL wide_reload: got %0h/%b exp ff/0",
        get_pout(4), out[4]);
    end
    cyc(4);
    up[4] = 1'b1;
    #1;
    n_chk++;
    if (get_pout(4) !== 16'hFE || out[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL wide_fe: got %0h/%b exp fe/0",
        get_pout(4), out[4]);
    end
    cyc(4);
    cyc(4);
    n_chk++;
    if (get_pout(4) !== 16'hFF || out[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL wide_top: got %0h/%b exp ff/1",
        get_pout(4), out[4]);
    end
    rst[4] = 1'b1;
  endtask

  task automatic test_random;
    for (int i = 0; i < 5; i++) begin
      up[i] = 1'b0;
      keep[i] = 1'b0;
      pulse_reset(i);
      for (int k = 0; k < 300; k++) begin
        up[i]   = 1'($urandom_range(0, 1));
        keep[i] = ($urandom_range(0, 5) == 0);
        rst[i]  = ($urandom_range(0, 60) == 0);
        #1;
        if (rst[i]) model_reset(i);
        n_chk++;
        if (out[i] !== exp_out(i)) begin
          n_fail++;
          $display("FAIL rnd_comb[%0d.%0d]: got %b exp %b",
            i, k, out[i], exp_out(i));
        end
        cyc(i);
        n_chk++;
        if (out[i] !== exp_out(i) ||
            get_pout(i) !== exp_pout(i)) begin
          n_fail++;
          $display("FAIL rnd[%0d.%0d]: got %0d/%b exp %0d/%b",
            i, k, get_pout(i), out[i],
            exp_pout(i), exp_out(i));
        end
      end
      rst[i] = 1'b1;
    end
  endtask

  initial begin
    clk    = 1'b0;
    rst    = '1;
    up     = '0;
    keep   = '0;
    n_chk  = 0;
    n_fail = 0;
    #2;
    test_reset;
    test_reload_down;
    test_prescale_keep;
    test_up_wrap;
    test_oneshot;
    test_async_reset;
    test_wide;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
